// File: rtl/alu_unit_pkg.sv
// alu_unit_pkg: shared widths, operation encodings and the result-queue entry type
package alu_unit_pkg;
  localparam int ROB_SZ_LOG = 4;
  localparam logic HIGH = 1'b1;
  localparam logic LOW = 1'b0;
  localparam logic [3:0] LAD = 4'd0;
  localparam logic [3:0] STR = 4'd1;
  localparam logic [3:0] ARITH = 4'd2;
  localparam logic [3:0] ARITHI = 4'd3;
  localparam logic [3:0] BRANCH = 4'd4;
  localparam logic [3:0] JAL = 4'd5;
  localparam logic [3:0] JALR = 4'd6;
  localparam logic [3:0] LUI = 4'd7;
  localparam logic [3:0] AUIPC = 4'd8;
  localparam logic [3:0] ADD = 4'd0;
  localparam logic [3:0] SUB = 4'd1;
  localparam logic [3:0] SLL = 4'd2;
  localparam logic [3:0] SLT = 4'd3;
  localparam logic [3:0] SLTU = 4'd4;
  localparam logic [3:0] XOR = 4'd5;
  localparam logic [3:0] SRL = 4'd6;
  localparam logic [3:0] SRA = 4'd7;
  localparam logic [3:0] OR = 4'd8;
  localparam logic [3:0] AND = 4'd9;
  localparam logic [3:0] BEQ = 4'd0;
  localparam logic [3:0] BNE = 4'd1;
  localparam logic [3:0] BLT = 4'd4;
  localparam logic [3:0] BGE = 4'd5;
  localparam logic [3:0] BLTU = 4'd6;
  localparam logic [3:0] BGEU = 4'd7;
  typedef struct packed {
    logic [ROB_SZ_LOG:0] rd;
    logic [31:0] res;
    logic brc;
    logic [31:0] tgt;
  } alu_ent_t;
endpackage

// File: rtl/alu_unit_exec.sv
// alu_exec: combinational RV32I integer and control-flow datapath
module alu_exec
  import alu_unit_pkg::*;
(
  input  logic [31:0] vj,
  input  logic [31:0] vk,
  input  logic [31:0] imm,
  input  logic [31:0] pc,
  input  logic [3:0]  opcode,
  input  logic [3:0]  optype,
  output logic [31:0] res,
  output logic        brc,
  output logic [31:0] tgt_pc
);
  logic [31:0] b;
  logic [31:0] pc4;
  logic [31:0] arith;
  logic [4:0]  sh;
  logic        taken;
  assign b = (optype == ARITHI) ? imm : vk;
  assign sh = b[4:0];
  assign pc4 = pc + 32'd4;
  // arithmetic result for register and immediate forms
  always_comb begin
    case (opcode)
      ADD:     arith = vj + b;
      SUB:     arith = vj - b;
      SLL:     arith = vj << sh;
      SLT:     arith = {31'b0, $signed(vj) < $signed(b)};
      SLTU:    arith = {31'b0, vj < b};
      XOR:     arith = vj ^ b;
      SRL:     arith = vj >> sh;
      SRA:     arith = 32'($signed(vj) >>> sh);
      OR:      arith = vj | b;
      AND:     arith = vj & b;
      default: arith = '0;
    endcase
  end
  // branch condition, always comparing the two register operands
  always_comb begin
    case (opcode)
      BEQ:     taken = vj == vk;
      BNE:     taken = vj != vk;
      BLT:     taken = $signed(vj) < $signed(vk);
      BGE:     taken = $signed(vj) >= $signed(vk);
      BLTU:    taken = vj < vk;
      BGEU:    taken = vj >= vk;
      default: taken = LOW;
    endcase
  end
  // select result, branch flag and actual next PC by instruction class
  always_comb begin
    res = '0;
    brc = LOW;
    tgt_pc = pc4;
    case (optype)
      ARITH, ARITHI: res = arith;
      LUI:           res = imm;
      AUIPC:         res = pc + imm;
      BRANCH: begin
        res = {31'b0, taken};
        brc = HIGH;
        tgt_pc = taken ? pc + imm : pc4;
      end
      JAL: begin
        res = pc4;
        brc = HIGH;
        tgt_pc = pc + imm;
      end
      JALR: begin
        res = pc4;
        brc = HIGH;
        tgt_pc = (vj + imm) & ~32'h1;
      end
      LAD, STR:      res = '0;
      default:       res = '0;
    endcase
  end
endmodule

// File: rtl/alu_unit.sv
// alu_unit: issue-side ALU with in-order result FIFO broadcasting on the ALU CDB
module alu_unit
  import alu_unit_pkg::*;
#(
  parameter int RES_Q_SZ = 4,
  parameter int RES_Q_SZ_LOG = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rdy,
  input  logic                  reset,
  input  logic                  run_cal,
  input  logic [31:0]           in_Vj,
  input  logic [31:0]           in_Vk,
  input  logic [31:0]           in_imm,
  input  logic [31:0]           in_pc,
  input  logic [3:0]            in_opcode,
  input  logic [3:0]            in_optype,
  input  logic [ROB_SZ_LOG:0]   in_dest,
  input  logic                  cdb_gnt,
  output logic                  alu_full,
  output logic                  run_upd_alu,
  output logic [ROB_SZ_LOG:0]   alu_rd,
  output logic [31:0]           alu_res,
  output logic                  alu_brc,
  output logic [31:0]           alu_tgt_pc
);
  localparam int CW = RES_Q_SZ_LOG + 1;
  localparam logic [CW-1:0] FULL_TH = CW'(RES_Q_SZ - 1);
  localparam logic [CW-1:0] Q_SZ = CW'(RES_Q_SZ);
  alu_ent_t mem_q [RES_Q_SZ];
  alu_ent_t mem_d [RES_Q_SZ];
  alu_ent_t ent;
  logic [RES_Q_SZ_LOG-1:0] head_q, head_d, tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic [31:0] ex_res, ex_tgt;
  logic ex_brc, push, pop;
  alu_exec u_exec (
    .vj(in_Vj),
    .vk(in_Vk),
    .imm(in_imm),
    .pc(in_pc),
    .opcode(in_opcode),
    .optype(in_optype),
    .res(ex_res),
    .brc(ex_brc),
    .tgt_pc(ex_tgt)
  );
  assign ent = '{rd: in_dest, res: ex_res, brc: ex_brc, tgt: ex_tgt};
  assign pop = run_upd_alu & cdb_gnt;
  assign push = run_cal & ((count_q != Q_SZ) | pop);
  assign run_upd_alu = count_q != '0;
  assign alu_full = count_q >= FULL_TH;
  assign alu_rd = mem_q[head_q].rd;
  assign alu_res = mem_q[head_q].res;
  assign alu_brc = mem_q[head_q].brc;
  assign alu_tgt_pc = mem_q[head_q].tgt;
  // next FIFO state: pause holds everything, flush empties, otherwise push/pop
  always_comb begin
    mem_d = mem_q;
    head_d = head_q;
    tail_d = tail_q;
    count_d = count_q;
    if (rdy && reset) begin
      head_d = '0;
      tail_d = '0;
      count_d = '0;
    end else if (rdy) begin
      if (push) mem_d[tail_q] = ent;
      tail_d = push ? tail_q + 1'b1 : tail_q;
      head_d = pop ? head_q + 1'b1 : head_q;
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end
  // state registers
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q <= '{default: '0};
      head_q <= '0;
      tail_q <= '0;
      count_q <= '0;
    end else begin
      mem_q <= mem_d;
      head_q <= head_d;
      tail_q <= tail_d;
      count_q <= count_d;
    end
  end
endmodule

// File: tb/tb_alu_unit.sv
// tb_alu_unit: scoreboard-driven checks of alu_unit broadcast order, flow control and flush
module tb_alu_unit;
  import alu_unit_pkg::*;
  logic clk = 1'b0;
  logic rst, rdy, reset, run_cal, cdb_gnt;
  logic [31:0] in_Vj, in_Vk, in_imm, in_pc;
  logic [3:0] in_opcode, in_optype;
  logic [ROB_SZ_LOG:0] in_dest;
  logic alu_full, run_upd_alu, alu_brc;
  logic [ROB_SZ_LOG:0] alu_rd;
  logic [31:0] alu_res, alu_tgt_pc;
  alu_ent_t sb[$];
  int n_cmp = 0;
  int n_err = 0;
  logic [ROB_SZ_LOG:0] tag = '0;

  alu_unit #(.RES_Q_SZ(4), .RES_Q_SZ_LOG(2)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .reset(reset), .run_cal(run_cal),
    .in_Vj(in_Vj), .in_Vk(in_Vk), .in_imm(in_imm), .in_pc(in_pc),
    .in_opcode(in_opcode), .in_optype(in_optype), .in_dest(in_dest),
    .cdb_gnt(cdb_gnt), .alu_full(alu_full), .run_upd_alu(run_upd_alu),
    .alu_rd(alu_rd), .alu_res(alu_res), .alu_brc(alu_brc), .alu_tgt_pc(alu_tgt_pc)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!rst && rdy && !reset && run_cal && sb.size() == 4 && !(run_upd_alu && cdb_gnt)) begin
      n_err++;
      $display("FAIL overflow: issue into full queue (size %0d)", sb.size());
    end
    if (!rst && rdy && !reset && run_upd_alu && cdb_gnt) begin
      n_cmp++;
      if (sb.size() == 0) begin
        n_err++;
        $display("FAIL broadcast: unexpected rd=%0d res=%h, scoreboard empty", alu_rd, alu_res);
      end else begin
        alu_ent_t e;
        e = sb.pop_front();
        if ({alu_rd, alu_res, alu_brc, alu_tgt_pc} !== e) begin
          n_err++;
          $display("FAIL broadcast: got rd=%0d res=%h brc=%b tgt=%h, want rd=%0d res=%h brc=%b tgt=%h",
                   alu_rd, alu_res, alu_brc, alu_tgt_pc, e.rd, e.res, e.brc, e.tgt);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [3:0] opt, input logic [3:0] opc, input logic [31:0] vj,
                       input logic [31:0] vk, input logic [31:0] imm, input logic [31:0] pc,
                       input logic [31:0] res, input logic brc, input logic [31:0] tgt);
    in_optype = opt;
    in_opcode = opc;
    in_Vj = vj;
    in_Vk = vk;
    in_imm = imm;
    in_pc = pc;
    in_dest = tag;
    run_cal = 1'b1;
    sb.push_back('{rd: tag, res: res, brc: brc, tgt: tgt});
    tag = tag + 1'b1;
    tick();
    run_cal = 1'b0;
  endtask

  task automatic test_reset();
    n_cmp++;
    if ({run_upd_alu, alu_full, alu_brc} !== 3'b000) begin
      n_err++;
      $display("FAIL reset_flags: got upd/full/brc=%b%b%b want 000", run_upd_alu, alu_full, alu_brc);
    end
    n_cmp++;
    if (alu_rd !== '0 || alu_res !== 32'h0 || alu_tgt_pc !== 32'h0) begin
      n_err++;
      $display("FAIL reset_data: got rd=%0d res=%h tgt=%h want 0", alu_rd, alu_res, alu_tgt_pc);
    end
  endtask

  task automatic test_add();
    cdb_gnt = 1'b1;
    tag = 5'd3;
    issue(ARITH, ADD, 32'd5, 32'd7, 32'd0, 32'h0, 32'd12, 1'b0, 32'h4);
    n_cmp++;
    if (run_upd_alu !== 1'b1 || alu_rd !== 5'd3 || alu_res !== 32'd12 || alu_brc !== 1'b0) begin
      n_err++;
      $display("FAIL add_latency: got upd=%b rd=%0d res=%0d brc=%b want 1 3 12 0", run_upd_alu, alu_rd, alu_res, alu_brc);
    end
    tick();
    n_cmp++;
    if (run_upd_alu !== 1'b0) begin
      n_err++;
      $display("FAIL add_drain: got upd=%b want 0", run_upd_alu);
    end
  endtask

  task automatic test_ctrl_flow();
    cdb_gnt = 1'b1;
    issue(BRANCH, BLT, 32'hFFFF_FFFF, 32'd1, 32'h20, 32'h100, 32'd1, 1'b1, 32'h120);
    issue(BRANCH, BLTU, 32'hFFFF_FFFF, 32'd1, 32'h20, 32'h100, 32'd0, 1'b1, 32'h104);
    issue(JALR, 4'd0, 32'h1001, 32'd0, 32'd2, 32'h40, 32'h44, 1'b1, 32'h1002);
    n_cmp++;
    if (alu_res !== 32'h44 || alu_tgt_pc !== 32'h1002) begin
      n_err++;
      $display("FAIL jalr: got res=%h tgt=%h want 44 1002", alu_res, alu_tgt_pc);
    end
    issue(ARITHI, SRA, 32'h8000_0000, 32'd0, 32'd4, 32'h50, 32'hF800_0000, 1'b0, 32'h54);
    tick();
  endtask

  task automatic test_back_to_back();
    cdb_gnt = 1'b1;
    issue(ARITH, SUB, 32'd3, 32'd5, 32'd0, 32'h10, 32'hFFFF_FFFE, 1'b0, 32'h14);
    issue(ARITHI, SLL, 32'd1, 32'd0, 32'd31, 32'h10, 32'h8000_0000, 1'b0, 32'h14);
    issue(ARITH, SLL, 32'd3, 32'h21, 32'd0, 32'h10, 32'd6, 1'b0, 32'h14);
    issue(ARITH, SLT, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'h10, 32'd1, 1'b0, 32'h14);
    issue(ARITH, SLTU, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'h10, 32'd0, 1'b0, 32'h14);
    issue(ARITHI, SRL, 32'h8000_0000, 32'd0, 32'd4, 32'h10, 32'h0800_0000, 1'b0, 32'h14);
    issue(ARITH, AND, 32'hF0F0, 32'hFF00, 32'd0, 32'h10, 32'hF000, 1'b0, 32'h14);
    issue(LUI, 4'd0, 32'd0, 32'd0, 32'h1234_5000, 32'h20, 32'h1234_5000, 1'b0, 32'h24);
    issue(AUIPC, 4'd0, 32'd0, 32'd0, 32'h2000, 32'h1000, 32'h3000, 1'b0, 32'h1004);
    issue(JAL, 4'd0, 32'd0, 32'd0, 32'h100, 32'h40, 32'h44, 1'b1, 32'h140);
    issue(BRANCH, BEQ, 32'd7, 32'd7, 32'hFFFF_FFF8, 32'h80, 32'd1, 1'b1, 32'h78);
    issue(BRANCH, BNE, 32'd7, 32'd7, 32'hFFFF_FFF8, 32'h80, 32'd0, 1'b1, 32'h84);
    issue(BRANCH, BGE, 32'hFFFF_FFFF, 32'd1, 32'h20, 32'h100, 32'd0, 1'b1, 32'h104);
    issue(BRANCH, BGEU, 32'hFFFF_FFFF, 32'd1, 32'h20, 32'h100, 32'd1, 1'b1, 32'h120);
    tick();
    n_cmp++;
    if (run_upd_alu !== 1'b0) begin
      n_err++;
      $display("FAIL b2b_drain: got upd=%b want 0", run_upd_alu);
    end
  endtask

  task automatic test_full();
    logic [2:0] want_full;
    want_full = 3'b100;
    cdb_gnt = 1'b0;
    tag = 5'd5;
    issue(ARITH, ADD, 32'd1, 32'd2, 32'd0, 32'h200, 32'd3, 1'b0, 32'h204);
    n_cmp++;
    if (alu_full !== want_full[0]) begin n_err++; $display("FAIL full_1: got %b want %b", alu_full, want_full[0]); end
    issue(ARITH, OR, 32'hF0, 32'h0F, 32'd0, 32'h200, 32'hFF, 1'b0, 32'h204);
    n_cmp++;
    if (alu_full !== want_full[1]) begin n_err++; $display("FAIL full_2: got %b want %b", alu_full, want_full[1]); end
    issue(ARITH, XOR, 32'hFF, 32'h0F, 32'd0, 32'h200, 32'hF0, 1'b0, 32'h204);
    n_cmp++;
    if (alu_full !== want_full[2]) begin n_err++; $display("FAIL full_3: got %b want %b", alu_full, want_full[2]); end
    tick();
    n_cmp++;
    if (run_upd_alu !== 1'b1 || alu_rd !== 5'd5 || alu_res !== 32'd3 || alu_full !== 1'b1) begin
      n_err++;
      $display("FAIL full_hold: got upd=%b rd=%0d res=%h full=%b want 1 5 3 1", run_upd_alu, alu_rd, alu_res, alu_full);
    end
    cdb_gnt = 1'b1;
    tick();
    n_cmp++;
    if (alu_full !== 1'b0 || alu_rd !== 5'd6) begin
      n_err++;
      $display("FAIL full_fall: got full=%b rd=%0d want 0 6", alu_full, alu_rd);
    end
    tick();
    tick();
    n_cmp++;
    if (run_upd_alu !== 1'b0) begin n_err++; $display("FAIL full_drain: got upd=%b want 0", run_upd_alu); end
  endtask

  task automatic test_flush();
    cdb_gnt = 1'b0;
    tag = 5'd8;
    issue(ARITH, ADD, 32'd1, 32'd1, 32'd0, 32'h0, 32'd2, 1'b0, 32'h4);
    issue(ARITH, ADD, 32'd2, 32'd2, 32'd0, 32'h0, 32'd4, 1'b0, 32'h4);
    reset = 1'b1;
    run_cal = 1'b1;
    in_dest = 5'd10;
    in_optype = ARITH;
    in_opcode = ADD;
    tick();
    reset = 1'b0;
    run_cal = 1'b0;
    sb.delete();
    n_cmp++;
    if (run_upd_alu !== 1'b0 || alu_full !== 1'b0) begin
      n_err++;
      $display("FAIL flush: got upd=%b full=%b want 0 0", run_upd_alu, alu_full);
    end
    cdb_gnt = 1'b1;
    tick();
    tick();
    n_cmp++;
    if (run_upd_alu !== 1'b0) begin n_err++; $display("FAIL flush_drop: got upd=%b want 0", run_upd_alu); end
    tag = 5'd11;
    issue(ARITH, ADD, 32'd9, 32'd9, 32'd0, 32'h8, 32'd18, 1'b0, 32'hC);
    n_cmp++;
    if (alu_rd !== 5'd11) begin n_err++; $display("FAIL flush_next: got rd=%0d want 11", alu_rd); end
    tick();
  endtask

  task automatic test_pause();
    cdb_gnt = 1'b0;
    tag = 5'd12;
    issue(ARITH, ADD, 32'd1, 32'd1, 32'd0, 32'h30, 32'd2, 1'b0, 32'h34);
    rdy = 1'b0;
    cdb_gnt = 1'b1;
    run_cal = 1'b1;
    in_dest = 5'd20;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++;
      if (run_upd_alu !== 1'b1 || alu_rd !== 5'd12 || alu_res !== 32'd2 || alu_tgt_pc !== 32'h34) begin
        n_err++;
        $display("FAIL pause_hold%0d: got upd=%b rd=%0d res=%h tgt=%h want 1 12 2 34", i, run_upd_alu, alu_rd, alu_res, alu_tgt_pc);
      end
    end
    run_cal = 1'b0;
    rdy = 1'b1;
    tick();
    n_cmp++;
    if (run_upd_alu !== 1'b0) begin n_err++; $display("FAIL pause_release: got upd=%b want 0", run_upd_alu); end
  endtask

  initial begin
    rst = 1'b1;
    rdy = 1'b1;
    reset = 1'b0;
    run_cal = 1'b0;
    cdb_gnt = 1'b0;
    in_Vj = '0;
    in_Vk = '0;
    in_imm = '0;
    in_pc = '0;
    in_opcode = '0;
    in_optype = '0;
    in_dest = '0;
    tick();
    tick();
    rst = 1'b0;
    test_reset();
    test_add();
    test_ctrl_flow();
    test_back_to_back();
    test_full();
    test_flush();
    test_pause();
    n_cmp++;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_empty: %0d entries never broadcast, want 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
